// File: rtl/digital_lock_fsm.sv
// Four-button combination lock controller.
// Registers the debounced N/W/S/E buttons and turns each 0 -> non-zero
// change into one key event. It checks a 4-press entry against the code
// S-W-E-W. A wrong entry raises a flashing alarm, which the sequence W, E
// clears. Board LEDs show entry progress and the RGB LED shows lock status.
module digital_lock_fsm #(
  parameter int unsigned flash_speed = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] nwse,
  output logic [3:0] led,
  output logic [2:0] rgb
);

  localparam logic [3:0] KEY_N = 4'b1000;
  localparam logic [3:0] KEY_W = 4'b0100;
  localparam logic [3:0] KEY_S = 4'b0010;
  localparam logic [3:0] KEY_E = 4'b0001;

  localparam int unsigned     CNT_W    = (flash_speed > 1) ? $clog2(flash_speed) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(flash_speed - 1);

  typedef enum logic [3:0] {
    IDLE,
    R1,
    R2,
    R3,
    W1,
    W2,
    W3,
    UNLOCK,
    ALARM,
    A1
  } state_t;

  logic [3:0]       nwse_q;
  logic [3:0]       nwse_prev_q;
  logic             key_ev;
  state_t           state_q;
  state_t           state_d;
  logic             flash_q;
  logic             flash_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Button sampling and one-cycle history for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      nwse_q      <= '0;
      nwse_prev_q <= '0;
    end else begin
      nwse_q      <= nwse;
      nwse_prev_q <= nwse_q;
    end
  end

  // A key event is the registered buttons leaving the all-released value.
  always_comb begin
    key_ev = (nwse_q != '0) && (nwse_prev_q == '0);
  end

  // State, flash bit and flash counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      flash_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      flash_q <= flash_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic. A multi-button press never matches a one-hot key, so it
  // always counts as a wrong key.
  always_comb begin
    state_d = state_q;
    if (key_ev) begin
      case (state_q)
        IDLE:    state_d = (nwse_q == KEY_S) ? R1 : W1;
        R1:      state_d = (nwse_q == KEY_W) ? R2 : W2;
        R2:      state_d = (nwse_q == KEY_E) ? R3 : W3;
        R3:      state_d = (nwse_q == KEY_W) ? UNLOCK : ALARM;
        W1:      state_d = W2;
        W2:      state_d = W3;
        W3:      state_d = ALARM;
        UNLOCK:  state_d = (nwse_q == KEY_N) ? IDLE : UNLOCK;
        ALARM:   state_d = (nwse_q == KEY_W) ? A1 : ALARM;
        A1:      state_d = (nwse_q == KEY_E) ? IDLE : ALARM;
        default: state_d = IDLE;
      endcase
    end
  end

  // Flash generator. Entering ALARM restarts the counter with the flash on.
  // Staying in ALARM toggles the flash every flash_speed cycles. In any other
  // state both are held cleared.
  always_comb begin
    flash_d = 1'b0;
    cnt_d   = '0;
    if (state_d == ALARM && state_q != ALARM) begin
      flash_d = 1'b1;
      cnt_d   = '0;
    end else if (state_q == ALARM) begin
      if (cnt_q == CNT_LAST) begin
        flash_d = ~flash_q;
        cnt_d   = '0;
      end else begin
        flash_d = flash_q;
        cnt_d   = cnt_q + 1'b1;
      end
    end
  end

  // Moore output decode from the state and the flash bit.
  always_comb begin
    led = '0;
    rgb = '0;
    case (state_q)
      IDLE: begin
        led = 4'b0000;
        rgb = 3'b000;
      end
      R1, W1: begin
        led = 4'b0001;
        rgb = 3'b001;
      end
      R2, W2: begin
        led = 4'b0011;
        rgb = 3'b001;
      end
      R3, W3: begin
        led = 4'b0111;
        rgb = 3'b001;
      end
      UNLOCK: begin
        led = 4'b1111;
        rgb = 3'b010;
      end
      ALARM: begin
        led = {4{flash_q}};
        rgb = {flash_q, 2'b00};
      end
      A1: begin
        led = 4'b0000;
        rgb = 3'b100;
      end
      default: begin
        led = '0;
        rgb = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_digital_lock_fsm.sv
// Randomized and directed bench for digital_lock_fsm.
// Two instances share the inputs: one with flash_speed=1 and one with
// flash_speed=3. A behavioural lock model predicts led/rgb for both.
module tb_digital_lock_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] nwse = '0;
  logic [3:0] led1, led3;
  logic [2:0] rgb1, rgb3;

  int checks = 0;
  int failures = 0;

  digital_lock_fsm #(.flash_speed(1)) dut1 (
    .clk(clk), .rst(rst), .nwse(nwse), .led(led1), .rgb(rgb1)
  );

  digital_lock_fsm #(.flash_speed(3)) dut3 (
    .clk(clk), .rst(rst), .nwse(nwse), .led(led3), .rgb(rgb3)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 entry, 1 unlocked, 2 alarm, 3 first disarm key seen
  logic [3:0] code [4] = '{4'b0010, 4'b0100, 4'b0001, 4'b0100};
  int         m_mode = 0;
  int         m_cnt  = 0;   // keys entered so far
  bit         m_ok   = 1;   // all entered keys correct
  int         m_age  = 0;   // cycles since entering alarm
  logic [3:0] m_q1 = '0, m_q2 = '0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic enter_alarm();
    m_mode = 2;
    m_age  = 0;
  endtask

  task automatic step_model();
    bit         ev;
    logic [3:0] k;
    if (rst) begin
      m_mode = 0; m_cnt = 0; m_ok = 1; m_age = 0;
      m_q1 = '0; m_q2 = '0;
      return;
    end
    ev = (m_q1 != 0) && (m_q2 == 0);
    k  = m_q1;
    if (m_mode == 2) m_age++;
    if (ev) begin
      case (m_mode)
        0: begin
          if (m_cnt < 3) begin
            m_ok = m_ok && (k == code[m_cnt]);
            m_cnt++;
          end else begin
            if (m_ok && k == code[3]) m_mode = 1;
            else enter_alarm();
            m_cnt = 0; m_ok = 1;
          end
        end
        1: if (k == 4'b1000) m_mode = 0;
        2: if (k == 4'b0100) m_mode = 3;
        default: begin
          if (k == 4'b0001) m_mode = 0;
          else enter_alarm();
        end
      endcase
    end
    m_q2 = m_q1;
    m_q1 = nwse;
  endtask

  function automatic logic [3:0] exp_led(input int fs);
    bit fl = ((m_age / fs) % 2) == 0;
    case (m_mode)
      0:       return 4'((1 << m_cnt) - 1);
      1:       return 4'hF;
      2:       return fl ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [2:0] exp_rgb(input int fs);
    bit fl = ((m_age / fs) % 2) == 0;
    case (m_mode)
      0:       return (m_cnt == 0) ? 3'b000 : 3'b001;
      1:       return 3'b010;
      2:       return fl ? 3'b100 : 3'b000;
      default: return 3'b100;
    endcase
  endfunction

  // One clock: check outputs at the falling edge, drive inputs, then step model.
  task automatic cycle(input logic [3:0] n, input logic r);
    @(negedge clk);
    chk("led_fs1", {4'b0, led1}, {4'b0, exp_led(1)});
    chk("rgb_fs1", {5'b0, rgb1}, {5'b0, exp_rgb(1)});
    chk("led_fs3", {4'b0, led3}, {4'b0, exp_led(3)});
    chk("rgb_fs3", {5'b0, rgb3}, {5'b0, exp_rgb(3)});
    nwse = n;
    rst  = r;
    @(posedge clk);
    step_model();
  endtask

  task automatic press(input logic [3:0] k, input int hold, input int gap);
    for (int i = 0; i < hold; i++) cycle(k, 1'b0);
    for (int i = 0; i < gap; i++) cycle(4'b0, 1'b0);
  endtask

  function automatic logic [3:0] wanted_key();
    case (m_mode)
      0:       return code[m_cnt];
      1:       return 4'b1000;
      2:       return 4'b0100;
      default: return 4'b0001;
    endcase
  endfunction

  initial begin
    logic [3:0] k;
    int         r;
    // initial reset; outputs are unknown before the first edge
    @(posedge clk); step_model();
    @(posedge clk); step_model();
    cycle(4'b0, 1'b1);
    cycle(4'b0, 1'b0);

    // correct code, E ignored when unlocked, N relocks
    press(4'b0010, 1, 3); press(4'b0100, 1, 3);
    press(4'b0001, 1, 3); press(4'b0100, 1, 3);
    press(4'b0001, 1, 3); press(4'b1000, 1, 3);
    // wrong code into alarm, then let it flash
    press(4'b0010, 1, 3); press(4'b0001, 1, 3);
    press(4'b0001, 1, 3); press(4'b0010, 1, 8);
    // disarm attempts
    press(4'b0001, 1, 3); press(4'b0100, 1, 3);
    press(4'b0010, 1, 5); press(4'b0100, 1, 3);
    press(4'b0001, 1, 3);
    // held button is a single event; chorded keys are one wrong key
    press(4'b0100, 10, 3); press(4'b1001, 1, 3);
    press(4'b0100, 1, 3); press(4'b0010, 1, 4);
    // reset mid-entry and during alarm
    press(4'b0010, 1, 2); press(4'b0100, 1, 3);
    cycle(4'b0, 1'b1); press(4'b0, 0, 2);
    press(4'b0010, 1, 1); press(4'b0010, 1, 1);
    press(4'b0010, 1, 1); press(4'b0010, 1, 4);
    cycle(4'b0001, 1'b1); press(4'b0, 0, 3);

    // randomized sessions
    for (int n = 0; n < 500; n++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        cycle(4'($urandom_range(0, 15)), 1'b1);
      end else begin
        if (r < 55)      k = wanted_key();
        else if (r < 88) k = 4'(1 << $urandom_range(0, 3));
        else             k = 4'($urandom_range(1, 15));
        press(k, $urandom_range(1, 4), $urandom_range(0, 3));
      end
    end
    press(4'b0, 0, 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
